// File: rtl/noc_pkt_tx_if.sv
// Link-side bundle for noc_pkt_tx: request, payload and symbol channels.
// master = initiator/link side, slave = packet transmitter.
interface noc_pkt_tx_if #(
   parameter int unsigned ADDR_BYTES = 8
) ();
   logic                    req_valid;
   logic                    req_ready;
   logic [2:0]              req_op;
   logic [7:0]              req_src;
   logic [2:0]              req_alen;
   logic [8*ADDR_BYTES-1:0] req_addr;
   logic [2:0]              req_size;
   logic [7:0]              pl_data;
   logic                    pl_valid;
   logic                    pl_ready;
   logic [8:0]              tx_sym;
   logic                    tx_valid;
   logic                    tx_ready;

   modport master (
      output req_valid, req_op, req_src, req_alen, req_addr, req_size,
      output pl_data, pl_valid, tx_ready,
      input  req_ready, pl_ready, tx_sym, tx_valid
   );

   modport slave (
      input  req_valid, req_op, req_src, req_alen, req_addr, req_size,
      input  pl_data, pl_valid, tx_ready,
      output req_ready, pl_ready, tx_sym, tx_valid
   );
endinterface

// File: rtl/noc_pkt_tx.sv
// Serialises one request into a 9-bit NoC packet:
// CMD, SRC, ADDR bytes, LEN, payload, CRC-8, END.
module noc_pkt_tx #(
   parameter logic [7:0]  CRC_POLY   = 8'h07,
   parameter logic [7:0]  CRC_INIT   = 8'h00,
   parameter int unsigned ADDR_BYTES = 8
) (
   input  logic          clk,
   input  logic          rst,
   noc_pkt_tx_if.slave   link,
   output logic          busy,
   output logic          err_op
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_SRC, ST_ADDR, ST_LEN, ST_DATA, ST_CRC, ST_END
   } state_t;

   localparam logic [2:0] ALEN_MAX = 3'(ADDR_BYTES - 1);

   state_t                  state_q, state_n;
   logic [2:0]              op_q;
   logic [7:0]              src_q;
   logic [2:0]              alen_q;
   logic [8*ADDR_BYTES-1:0] addr_q, addr_n;
   logic [2:0]              size_q;
   logic [7:0]              crc_q, crc_n;
   logic [2:0]              k_q;
   logic [3:0]              dcnt_q;
   logic [8:0]              sym_q, sym_n;
   logic                    err_q;

   logic                    tx_valid;
   logic [8:0]              tx_sym;
   logic                    hs;
   logic                    accept;
   logic                    legal;
   logic                    has_data;
   logic [2:0]              alen_clip;

   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

   function automatic logic [3:0] pl_bytes(input logic [2:0] size);
      logic [3:0] n;
      case (size)
         3'd0:    n = 4'd1;
         3'd1:    n = 4'd2;
         3'd2:    n = 4'd3;
         3'd3:    n = 4'd4;
         3'd4:    n = 4'd5;
         3'd5:    n = 4'd7;
         3'd6:    n = 4'd8;
         default: n = 4'd12;
      endcase
      return n;
   endfunction

   assign alen_clip = (32'(link.req_alen) >= ADDR_BYTES) ? ALEN_MAX : link.req_alen;
   assign legal     = !(link.req_op == 3'b000 || link.req_op == 3'b101 || link.req_op == 3'b111);
   assign has_data  = (op_q == 3'b010) || (op_q == 3'b011) || (op_q == 3'b110);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      sym_n    = sym_q;
      accept   = (state_q == ST_IDLE) && link.req_valid;
      // DATA forwards the payload stream straight onto the link
      tx_valid = (state_q == ST_DATA) ? link.pl_valid : (state_q != ST_IDLE);
      tx_sym   = (state_q == ST_DATA) ? {1'b0, link.pl_data} : sym_q;
      hs       = tx_valid && link.tx_ready;

      crc_n = crc_q;
      if (hs && (state_q == ST_SRC || state_q == ST_ADDR ||
                 state_q == ST_LEN || state_q == ST_DATA)) begin
         crc_n = crc8_step(crc_q, tx_sym[7:0]);
      end

      addr_n = addr_q;
      if (hs && state_q == ST_ADDR) begin
         addr_n = addr_q >> 8;
      end

      case (state_q)
         ST_IDLE: if (accept && legal) state_n = ST_CMD;
         ST_CMD:  if (hs) state_n = ST_SRC;
         ST_SRC:  if (hs) state_n = ST_ADDR;
         ST_ADDR: if (hs && k_q == alen_q) state_n = ST_LEN;
         ST_LEN:  if (hs) state_n = has_data ? ST_DATA : ST_CRC;
         ST_DATA: if (hs && dcnt_q == (pl_bytes(size_q) - 4'd1)) state_n = ST_CRC;
         ST_CRC:  if (hs) state_n = ST_END;
         ST_END:  if (hs) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase

      // Symbol for the state being entered, so tx_sym leaves a flop and holds during stalls
      case (state_n)
         ST_IDLE: sym_n = 9'h100;
         ST_CMD:  sym_n = (state_q == ST_IDLE) ? {1'b1, link.req_op, alen_clip, 2'b00} : sym_q;
         ST_SRC:  sym_n = {1'b0, src_q};
         ST_ADDR: sym_n = {1'b0, addr_n[7:0]};
         ST_LEN:  sym_n = {1'b0, 5'b0, size_q};
         ST_DATA: sym_n = 9'h100;
         ST_CRC:  sym_n = {1'b0, crc_n};
         ST_END:  sym_n = 9'h1E0;
         default: sym_n = 9'h100;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         src_q  <= '0;
         alen_q <= '0;
         addr_q <= '0;
         size_q <= '0;
         crc_q  <= CRC_INIT;
         k_q    <= '0;
         dcnt_q <= '0;
         sym_q  <= 9'h100;
         err_q  <= 1'b0;
      end else begin
         err_q <= accept && !legal;
         sym_q <= sym_n;
         if (accept) begin
            op_q   <= link.req_op;
            src_q  <= link.req_src;
            alen_q <= alen_clip;
            addr_q <= link.req_addr;
            size_q <= link.req_size;
            crc_q  <= CRC_INIT;
            k_q    <= '0;
            dcnt_q <= '0;
         end else begin
            crc_q  <= crc_n;
            addr_q <= addr_n;
            if (hs && state_q == ST_ADDR) k_q <= k_q + 3'd1;
            if (hs && state_q == ST_DATA) dcnt_q <= dcnt_q + 4'd1;
         end
      end
   end

   assign link.req_ready = (state_q == ST_IDLE);
   assign link.pl_ready  = (state_q == ST_DATA) && link.tx_ready;
   assign link.tx_valid  = tx_valid;
   assign link.tx_sym    = tx_sym;
   assign busy           = (state_q != ST_IDLE);
   assign err_op         = err_q;

endmodule
